// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int          PC_W      = 16;
    localparam logic [15:0] RESET_PC  = 16'h0000;
    localparam logic [15:0] NOP_INSTR = 16'h0800;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_HOLD,
        ST_DROP,
        ST_HALTED
    } fetch_state_e;

    // 16-bit wrap-around: 16'hFFFE advances to 16'h0000.
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(2);
    endfunction

endpackage

// File: rtl/dff.sv
// Team register cell: W-bit D flip-flop with synchronous active-high reset.
module dff #(
    parameter int         W       = 16,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) q_o <= RST_VAL;
        else     q_o <= d_i;
    end

endmodule

// File: rtl/fetch_hold_buf.sv
// One-entry instruction/PC+2 buffer that catches a fetch completing while decode stalls.
module fetch_hold_buf
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            drain_i,
    input  logic            clear_i,
    input  logic [15:0]     instr_i,
    input  logic [PC_W-1:0] pc_plus2_i,
    output logic            full_o,
    output logic [15:0]     instr_o,
    output logic [PC_W-1:0] pc_plus2_o
);

    logic            full_q;
    logic [15:0]     instr_q;
    logic [PC_W-1:0] pc_plus2_q;

    always_ff @(posedge clk) begin
        if (rst || clear_i || drain_i) full_q <= 1'b0;
        else if (load_i)               full_q <= 1'b1;
    end

    // NOTE: payload registers carry no reset; they are only read while full_q is set.
    always_ff @(posedge clk) begin
        if (load_i) begin
            instr_q    <= instr_i;
            pc_plus2_q <= pc_plus2_i;
        end
    end

    assign full_o     = full_q;
    assign instr_o    = instr_q;
    assign pc_plus2_o = pc_plus2_q;

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, drives imem, presents IF/ID to decode.
// Optional misaligned-fetch trap enabled by defining FETCH_ALIGN_ERR_EN.
module fetch
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            Redirect,
    input  logic [PC_W-1:0] PC_Target,
    input  logic            Stall,
    input  logic            Halt,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_rd,
    input  logic [15:0]     imem_data,
    input  logic            imem_stall,
    input  logic            imem_done,
    output logic [15:0]     instr,
    output logic [15:0]     instr_comb,
    output logic [PC_W-1:0] PC_plus2,
    output logic            valid,
    output logic            err
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pend_q, pend_d;
    logic            halt_pend_q, halt_pend_d;
    logic [15:0]     instr_d;
    logic [PC_W-1:0] pc2_d;
    logic            valid_d;
    logic [PC_W-1:0] pc_next;
    logic            misaligned;

    logic            buf_load, buf_drain, buf_clear, buf_full;
    logic [15:0]     buf_instr;
    logic [PC_W-1:0] buf_pc2;

    assign pc_next = pc_inc(pc_q);

    dff #(.W(PC_W), .RST_VAL(RESET_PC))  u_pc    (.clk(clk), .rst(rst), .d_i(pc_d),    .q_o(pc_q));
    dff #(.W(PC_W), .RST_VAL('0))        u_pend  (.clk(clk), .rst(rst), .d_i(pend_d),  .q_o(pend_q));
    dff #(.W(16),   .RST_VAL(NOP_INSTR)) u_instr (.clk(clk), .rst(rst), .d_i(instr_d), .q_o(instr));
    dff #(.W(PC_W), .RST_VAL('0))        u_pc2   (.clk(clk), .rst(rst), .d_i(pc2_d),   .q_o(PC_plus2));
    dff #(.W(1),    .RST_VAL(1'b0))      u_valid (.clk(clk), .rst(rst), .d_i(valid_d), .q_o(valid));

    fetch_hold_buf u_hold_buf (
        .clk        (clk),
        .rst        (rst),
        .load_i     (buf_load),
        .drain_i    (buf_drain),
        .clear_i    (buf_clear),
        .instr_i    (imem_data),
        .pc_plus2_i (pc_next),
        .full_o     (buf_full),
        .instr_o    (buf_instr),
        .pc_plus2_o (buf_pc2)
    );

`ifdef FETCH_ALIGN_ERR_EN
    logic err_q;

    assign misaligned = pc_q[0];

    always_ff @(posedge clk) begin
        if (rst)                                    err_q <= 1'b0;
        else if (state_q == ST_FETCH && misaligned) err_q <= 1'b1;
    end

    assign err = err_q;
`else
    assign misaligned = 1'b0;
    assign err        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FETCH;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    assign imem_addr  = pc_q;
    assign instr_comb = (state_q == ST_FETCH && imem_done) ? imem_data : NOP_INSTR;

    // NOTE: every signal written below gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_d      = pend_q;
        halt_pend_d = halt_pend_q;
        instr_d     = instr;
        pc2_d       = PC_plus2;
        valid_d     = valid;
        buf_load    = 1'b0;
        buf_drain   = 1'b0;
        buf_clear   = 1'b0;
        imem_rd     = 1'b0;

        case (state_q)
            ST_FETCH: begin
                if (misaligned) begin
                    instr_d   = NOP_INSTR;
                    valid_d   = 1'b0;
                    buf_clear = 1'b1;
                    state_d   = ST_HALTED;
                end else begin
                    imem_rd = 1'b1;
                    if (Redirect) begin
                        instr_d   = NOP_INSTR;
                        valid_d   = 1'b0;
                        buf_clear = 1'b1;
                        if (imem_stall) begin
                            pend_d  = PC_Target;
                            state_d = ST_DROP;
                        end else begin
                            pc_d = PC_Target;
                        end
                    end else if (Halt) begin
                        instr_d   = NOP_INSTR;
                        valid_d   = 1'b0;
                        buf_clear = 1'b1;
                        // An in-flight access must finish before halting; DROP absorbs it.
                        if (imem_stall) begin
                            halt_pend_d = 1'b1;
                            state_d     = ST_DROP;
                        end else begin
                            state_d = ST_HALTED;
                        end
                    end else if (imem_done) begin
                        pc_d = pc_next;
                        if (Stall) begin
                            buf_load = 1'b1;
                            state_d  = ST_HOLD;
                        end else begin
                            instr_d = imem_data;
                            pc2_d   = pc_next;
                            valid_d = 1'b1;
                        end
                    end else if (!Stall) begin
                        instr_d = NOP_INSTR;
                        valid_d = 1'b0;
                    end
                end
            end

            ST_HOLD: begin
                if (Redirect) begin
                    instr_d   = NOP_INSTR;
                    valid_d   = 1'b0;
                    buf_clear = 1'b1;
                    pc_d      = PC_Target;
                    state_d   = ST_FETCH;
                end else if (Halt) begin
                    instr_d   = NOP_INSTR;
                    valid_d   = 1'b0;
                    buf_clear = 1'b1;
                    state_d   = ST_HALTED;
                end else if (!Stall) begin
                    instr_d   = buf_full ? buf_instr : NOP_INSTR;
                    pc2_d     = buf_full ? buf_pc2 : PC_plus2;
                    valid_d   = buf_full;
                    buf_drain = 1'b1;
                    state_d   = ST_FETCH;
                end
            end

            ST_DROP: begin
                imem_rd = 1'b1;
                if (Redirect) begin
                    pend_d      = PC_Target;
                    halt_pend_d = 1'b0;
                end else if (Halt) begin
                    halt_pend_d = 1'b1;
                end
                if (imem_done) begin
                    if (halt_pend_d) begin
                        state_d = ST_HALTED;
                    end else begin
                        pc_d    = pend_d;
                        state_d = ST_FETCH;
                    end
                end
            end

            ST_HALTED: begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end

            default: state_d = ST_FETCH;
        endcase
    end

endmodule

// File: tb/tb_fetch.sv
// Directed self-checking bench for the fetch stage; memory word at address A is 16'hA000 + A/2.
module tb_fetch;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        Redirect;
    logic [15:0] PC_Target;
    logic        Stall;
    logic        Halt;
    logic [15:0] imem_addr;
    logic        imem_rd;
    logic [15:0] imem_data;
    logic        imem_stall;
    logic        imem_done;
    logic [15:0] instr;
    logic [15:0] instr_comb;
    logic [15:0] PC_plus2;
    logic        valid;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;
    int rd6_cnt = 0;

    always #5 clk = ~clk;

    fetch dut (
        .clk        (clk),
        .rst        (rst),
        .Redirect   (Redirect),
        .PC_Target  (PC_Target),
        .Stall      (Stall),
        .Halt       (Halt),
        .imem_addr  (imem_addr),
        .imem_rd    (imem_rd),
        .imem_data  (imem_data),
        .imem_stall (imem_stall),
        .imem_done  (imem_done),
        .instr      (instr),
        .instr_comb (instr_comb),
        .PC_plus2   (PC_plus2),
        .valid      (valid),
        .err        (err)
    );

    always_comb imem_data = 16'hA000 + {1'b0, imem_addr[15:1]};

    always @(posedge clk)
        if (!rst && imem_rd && imem_done && imem_addr == 16'h0006) rd6_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; Redirect = 1'b0; PC_Target = '0; Stall = 1'b0; Halt = 1'b0;
        imem_stall = 1'b0; imem_done = 1'b1;
        tick(); tick();
        n_cmp++; if (instr !== 16'h0800) begin n_bad++; $display("FAIL reset_instr got %h want 0800", instr); end
        n_cmp++; if (PC_plus2 !== 16'h0000) begin n_bad++; $display("FAIL reset_pc2 got %h want 0000", PC_plus2); end
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", valid); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
        n_cmp++; if (imem_addr !== 16'h0000) begin n_bad++; $display("FAIL reset_addr got %h want 0000", imem_addr); end
        rst = 1'b0;
        #1;
        n_cmp++; if (imem_rd !== 1'b1) begin n_bad++; $display("FAIL first_rd got %b want 1", imem_rd); end
        n_cmp++; if (instr_comb !== 16'hA000) begin n_bad++; $display("FAIL first_comb got %h want a000", instr_comb); end
    endtask

    task automatic test_single_cycle();
        logic [15:0] exp_i, exp_p;
        for (int k = 0; k < 3; k++) begin
            tick();
            exp_i = 16'hA000 + 16'(k);
            exp_p = 16'(2 * (k + 1));
            n_cmp++; if (instr !== exp_i) begin n_bad++; $display("FAIL seq_instr[%0d] got %h want %h", k, instr, exp_i); end
            n_cmp++; if (PC_plus2 !== exp_p) begin n_bad++; $display("FAIL seq_pc2[%0d] got %h want %h", k, PC_plus2, exp_p); end
            n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL seq_valid[%0d] got %b want 1", k, valid); end
        end
        n_cmp++; if (imem_addr !== 16'h0006) begin n_bad++; $display("FAIL seq_addr got %h want 0006", imem_addr); end
    endtask

    task automatic test_stall();
        rd6_cnt = 0;
        Stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (instr !== 16'hA002) begin n_bad++; $display("FAIL stall_instr[%0d] got %h want a002", k, instr); end
            n_cmp++; if (PC_plus2 !== 16'h0006) begin n_bad++; $display("FAIL stall_pc2[%0d] got %h want 0006", k, PC_plus2); end
        end
        n_cmp++; if (imem_rd !== 1'b0) begin n_bad++; $display("FAIL hold_rd got %b want 0", imem_rd); end
        Stall = 1'b0;
        tick();
        n_cmp++; if (instr !== 16'hA003) begin n_bad++; $display("FAIL release_instr got %h want a003", instr); end
        n_cmp++; if (PC_plus2 !== 16'h0008) begin n_bad++; $display("FAIL release_pc2 got %h want 0008", PC_plus2); end
        n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL release_valid got %b want 1", valid); end
        n_cmp++; if (rd6_cnt !== 1) begin n_bad++; $display("FAIL addr6_reads got %0d want 1", rd6_cnt); end
        tick();
        n_cmp++; if (instr !== 16'hA004) begin n_bad++; $display("FAIL after_hold_instr got %h want a004", instr); end
    endtask

    task automatic test_redirect();
        Redirect = 1'b1; PC_Target = 16'h0040;
        tick();
        Redirect = 1'b0;
        n_cmp++; if (instr !== 16'h0800) begin n_bad++; $display("FAIL redir_instr got %h want 0800", instr); end
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL redir_valid got %b want 0", valid); end
        n_cmp++; if (imem_addr !== 16'h0040) begin n_bad++; $display("FAIL redir_addr got %h want 0040", imem_addr); end
        tick();
        n_cmp++; if (instr !== 16'hA020) begin n_bad++; $display("FAIL redir_target_instr got %h want a020", instr); end
        n_cmp++; if (PC_plus2 !== 16'h0042) begin n_bad++; $display("FAIL redir_target_pc2 got %h want 0042", PC_plus2); end
    endtask

    task automatic test_redirect_multicycle();
        imem_done = 1'b0; imem_stall = 1'b1;
        tick();
        n_cmp++; if (valid !== 1'b0 || instr !== 16'h0800) begin n_bad++; $display("FAIL bubble got %h/%b want 0800/0", instr, valid); end
        Redirect = 1'b1; PC_Target = 16'h0100;
        tick();
        Redirect = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (imem_addr !== 16'h0042 || imem_rd !== 1'b1) begin n_bad++; $display("FAIL drop_hold[%0d] got %h/%b want 0042/1", k, imem_addr, imem_rd); end
            tick();
        end
        imem_stall = 1'b0; imem_done = 1'b1;
        #1;
        n_cmp++; if (instr_comb !== 16'h0800) begin n_bad++; $display("FAIL drop_comb got %h want 0800", instr_comb); end
        tick();
        n_cmp++; if (instr !== 16'h0800 || valid !== 1'b0) begin n_bad++; $display("FAIL drop_discard got %h/%b want 0800/0", instr, valid); end
        n_cmp++; if (imem_addr !== 16'h0100) begin n_bad++; $display("FAIL drop_addr got %h want 0100", imem_addr); end
        tick();
        n_cmp++; if (instr !== 16'hA080) begin n_bad++; $display("FAIL drop_target_instr got %h want a080", instr); end
    endtask

    task automatic test_halt();
        Halt = 1'b1;
        tick();
        Halt = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (imem_rd !== 1'b0 || valid !== 1'b0 || imem_addr !== 16'h0102) begin
                n_bad++; $display("FAIL halted[%0d] got rd=%b v=%b a=%h want 0/0/0102", k, imem_rd, valid, imem_addr);
            end
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (imem_addr !== 16'h0000 || imem_rd !== 1'b1) begin n_bad++; $display("FAIL restart got %h/%b want 0000/1", imem_addr, imem_rd); end
        tick();
        n_cmp++; if (instr !== 16'hA000) begin n_bad++; $display("FAIL restart_instr got %h want a000", instr); end
    endtask

    task automatic test_align();
        Redirect = 1'b1; PC_Target = 16'h0013;
        tick();
        Redirect = 1'b0;
        #1;
        n_cmp++; if (imem_addr !== 16'h0013) begin n_bad++; $display("FAIL align_addr got %h want 0013", imem_addr); end
`ifdef FETCH_ALIGN_ERR_EN
        n_cmp++; if (imem_rd !== 1'b0) begin n_bad++; $display("FAIL align_rd got %b want 0", imem_rd); end
        tick();
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL align_err got %b want 1", err); end
        tick();
        n_cmp++; if (err !== 1'b1 || imem_rd !== 1'b0 || valid !== 1'b0) begin
            n_bad++; $display("FAIL align_halted got err=%b rd=%b v=%b want 1/0/0", err, imem_rd, valid);
        end
`else
        n_cmp++; if (imem_rd !== 1'b1) begin n_bad++; $display("FAIL align_rd got %b want 1", imem_rd); end
        tick();
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL align_err got %b want 0", err); end
        n_cmp++; if (instr !== 16'hA009 || PC_plus2 !== 16'h0015) begin
            n_bad++; $display("FAIL align_fetch got %h/%h want a009/0015", instr, PC_plus2);
        end
`endif
    endtask

    task automatic test_rst_mid_hold();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        Stall = 1'b1;
        tick();
        n_cmp++; if (imem_rd !== 1'b0 || instr !== 16'hA000) begin n_bad++; $display("FAIL pre_rst_hold got rd=%b i=%h want 0/a000", imem_rd, instr); end
        rst = 1'b1;
        tick();
        rst = 1'b0; Stall = 1'b0;
        #1;
        n_cmp++; if (instr !== 16'h0800 || valid !== 1'b0 || imem_addr !== 16'h0000 || err !== 1'b0) begin
            n_bad++; $display("FAIL rst_hold got i=%h v=%b a=%h e=%b want 0800/0/0000/0", instr, valid, imem_addr, err);
        end
        n_cmp++; if (imem_rd !== 1'b1) begin n_bad++; $display("FAIL rst_hold_rd got %b want 1", imem_rd); end
        tick();
        n_cmp++; if (instr !== 16'hA000 || PC_plus2 !== 16'h0002) begin n_bad++; $display("FAIL rst_hold_fetch got %h/%h want a000/0002", instr, PC_plus2); end
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_stall();
        test_redirect();
        test_redirect_multicycle();
        test_halt();
        test_align();
        test_rst_mid_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch.md
# fetch

Instruction-fetch stage sitting directly upstream of `decode`. Owns the architectural PC and drives the instruction-memory read port. Presents a flopped instruction/PC+2 pair to decode, with a one-entry hold buffer so decode stalls never cause a re-fetch. Handles branch/jump redirects (including ones that arrive during a multi-cycle memory access) and freezes on HALT.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `NOP_INSTR`, 16'h0800, encoding presented to decode when no valid instruction is available (decodes as NOP).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `Redirect`  in  1  branch/jump taken in decode; load `PC_Target`.
- `PC_Target`  in  16  redirect destination.
- `Stall`  in  1  decode hazard stall; hold the IF/ID outputs.
- `Halt`  in  1  HALT decoded; stop fetching.
- `imem_addr`  out  16  fetch address (equals PC register).
- `imem_rd`  out  1  read request.
- `imem_data`  in  16  read data, valid when `imem_done`.
- `imem_stall`  in  1  memory busy; address must be held.
- `imem_done`  in  1  read complete this cycle.
- `instr`  out  16  flopped instruction to decode.
- `instr_comb`  out  16  `imem_data` when `imem_done` in FETCH, else `NOP_INSTR`.
- `PC_plus2`  out  16  flopped PC+2 of `instr`.
- `valid`  out  1  `instr` is a real fetched instruction.
- `err`  out  1  misaligned fetch (see Configuration).

## Operation
- States: FETCH, HOLD, DROP, HALTED.
- FETCH: `imem_rd`=1, `imem_addr`=PC.
  - On `imem_done` & !`Stall`: `instr`<=`imem_data`, `PC_plus2`<=PC+2, `valid`<=1, PC<=PC+2.
  - On `imem_done` & `Stall`: data goes into hold buffer, PC<=PC+2, go HOLD. IF/ID outputs are unchanged.
  - No done & !`Stall`: `instr`<=`NOP_INSTR`, `valid`<=0.
- HOLD: `imem_rd`=0. When `Stall` drops, move buffer to IF/ID and go FETCH.
- Redirect priority: `Redirect` > `Halt` > `Stall`.
  - With `imem_stall`=0: PC<=`PC_Target`, IF/ID<=NOP/`valid`=0, hold buffer cleared, go FETCH.
  - With `imem_stall`=1: latch target into `pend_pc` and go DROP. Hold `imem_addr` until `imem_done`, discard that data, then PC<=`pend_pc` and go FETCH.
  - A second `Redirect` in DROP overwrites `pend_pc`.
- Redirect overrides `Stall`: IF/ID is flushed even if `Stall`=1.
- `Halt`:
  - Go HALTED; `imem_rd`=0, PC frozen, IF/ID<=NOP, `valid`=0.
  - If a memory access is in flight, the access completes and its data is discarded.
  - HALTED is left only by `rst`.
- PC arithmetic is 16-bit, wrap-around: 16'hFFFE+2 = 16'h0000.

## Timing
- Reset (sync, next edge):
  - PC=`RESET_PC`, state FETCH.
  - `instr`=`NOP_INSTR`, `PC_plus2`=0, `valid`=0, `err`=0.
  - Hold buffer empty, `pend_pc`=0.
- First request is issued the cycle `rst` is low.
- Single-cycle memory (`imem_done` same cycle as request): one instruction per cycle. Latency from request to `instr` is 1 edge.
- Multi-cycle memory: `imem_addr` is held stable while `imem_stall`=1. `valid`=0 bubbles are inserted into IF/ID.
- Redirect during a single-cycle access: target fetch is issued the next cycle, and the wrong-path instruction never reaches IF/ID. Redirect penalty is 1 bubble (no memory wait).
- `rst` mid-DROP or mid-HOLD: abandons all state at the next edge.

## Configuration
- `FETCH_ALIGN_ERR_EN` defined:
  - A fetch with PC[0]=1 asserts `err` (sticky until `rst`) on the edge it would be issued.
  - `imem_rd` is not asserted for that fetch, and the block enters HALTED.
- `FETCH_ALIGN_ERR_EN` undefined: `err` tied 0 and PC[0] passed unchecked.

## Structure
- Shared package `fetch_pkg`:
  - state enum (FETCH/HOLD/DROP/HALTED);
  - `NOP_INSTR` and `RESET_PC` constants;
  - `PC_W`=16.
- One sub-module `fetch_hold_buf`: one-entry instruction/PC+2 buffer with load/drain/clear and a full flag.
- PC, IF/ID and `pend_pc` registers are built from the team `dff` cell.

## Test plan
- Reset, single-cycle memory returning 16'hA000, 16'hA001, …: `instr` sequence is A000, A001, …; `PC_plus2` is 2, 4, …; `valid`=1 from the second edge.
- `Stall` high for 3 cycles after fetching PC 4: `instr` is held and the memory address 6 is read exactly once. On release, `instr` = word at 6 with `PC_plus2`=8.
- `Redirect` to 16'h0040 with single-cycle memory: next IF/ID is NOP with `valid`=0, next `imem_addr` is 0x0040, and the wrong-path word never appears in IF/ID.
- Memory with `imem_stall` for 4 cycles; `Redirect` to 0x0100 in cycle 2: address is held until `imem_done`, that data is discarded, then `imem_addr`=0x0100.
- `Halt` asserted: `imem_rd`=0, `valid`=0 and PC frozen indefinitely; `rst` restarts at 0.
- With `FETCH_ALIGN_ERR_EN`, `Redirect` to 0x0013: `err`=1 and HALTED. Without the macro: `err`=0 and `imem_addr`=0x0013.
